l2cache_victim_writeback: RTL and testbench

//  Read-side companion of the L2 way-valid load path: on an L2 miss, selects the victim way by LRU.

---
 rtl/l2cache_types.sv | 15 +
 rtl/l2cache_way_mux.sv | 28 ++
 rtl/l2cache_victim_writeback.sv | 97 +++++++++
 tb/tb_l2cache_victim_writeback.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/l2cache_types.sv
// Shared L2 types and geometry: victim-writeback FSM states and line/address field widths.
package l2cache_types;

    localparam int TAG_W    = 24;
    localparam int IDX_W    = 3;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        DONE = 2'd2
    } victim_state_t;

endpackage

// File: rtl/l2cache_way_mux.sv
// Selects one way's valid/dirty/tag/data from the two ways of a 2-way set.
module l2cache_way_mux
    import l2cache_types::*;
#(
    parameter int TW = TAG_W,
    parameter int LW = LINE_W
) (
    input  logic          way_sel,
    input  logic          valid_0,
    input  logic          valid_1,
    input  logic          dirty_0,
    input  logic          dirty_1,
    input  logic [TW-1:0] tag_0,
    input  logic [TW-1:0] tag_1,
    input  logic [LW-1:0] data_0,
    input  logic [LW-1:0] data_1,
    output logic          valid,
    output logic          dirty,
    output logic [TW-1:0] tag,
    output logic [LW-1:0] data
);

    assign valid = way_sel ? valid_1 : valid_0;
    assign dirty = way_sel ? dirty_1 : dirty_0;
    assign tag   = way_sel ? tag_1   : tag_0;
    assign data  = way_sel ? data_1  : data_0;

endmodule

// File: rtl/l2cache_victim_writeback.sv
// Frees the LRU way of a set on an L2 miss, writing the line back to pmem first when it is dirty.
module l2cache_victim_writeback
    import l2cache_types::*;
#(
    parameter int TW = TAG_W,
    parameter int IW = IDX_W,
    parameter int OW = OFFSET_W,
    parameter int LW = LINE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                evict_req,
    input  logic [IW-1:0]       index,
    input  logic                lru,
    input  logic                valid_0,
    input  logic                valid_1,
    input  logic                dirty_0,
    input  logic                dirty_1,
    input  logic [TW-1:0]       tag_0,
    input  logic [TW-1:0]       tag_1,
    input  logic [LW-1:0]       data_0,
    input  logic [LW-1:0]       data_1,
    input  logic                pmem_resp,
    output logic                pmem_write,
    output logic [TW+IW+OW-1:0] pmem_address,
    output logic [LW-1:0]       pmem_wdata,
    output logic                victim_way,
    output logic                clear_dirty_0,
    output logic                clear_dirty_1,
    output logic                evict_done,
    output logic                busy
);

    victim_state_t state_q;
    logic          victim_q;
    logic [TW-1:0] tag_q;
    logic [IW-1:0] index_q;
    logic [LW-1:0] data_q;

    logic          sel_valid;
    logic          sel_dirty;
    logic [TW-1:0] sel_tag;
    logic [LW-1:0] sel_data;

    l2cache_way_mux #(.TW(TW), .LW(LW)) u_way_mux (
        .way_sel (lru),
        .valid_0 (valid_0),
        .valid_1 (valid_1),
        .dirty_0 (dirty_0),
        .dirty_1 (dirty_1),
        .tag_0   (tag_0),
        .tag_1   (tag_1),
        .data_0  (data_0),
        .data_1  (data_1),
        .valid   (sel_valid),
        .dirty   (sel_dirty),
        .tag     (sel_tag),
        .data    (sel_data)
    );

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            tag_q    <= '0;
            index_q  <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Array inputs are captured only here; later array writes cannot disturb WB.
                    if (evict_req) begin
                        victim_q <= lru;
                        tag_q    <= sel_tag;
                        index_q  <= index;
                        data_q   <= sel_data;
                        state_q  <= (sel_valid && sel_dirty) ? WB : DONE;
                    end
                end
                WB:      if (pmem_resp) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_write    = (state_q == WB);
    assign pmem_address  = {tag_q, index_q, {OW{1'b0}}};
    assign pmem_wdata    = data_q;
    assign victim_way    = victim_q;
    assign clear_dirty_0 = pmem_write && pmem_resp && !victim_q;
    assign clear_dirty_1 = pmem_write && pmem_resp &&  victim_q;
    assign evict_done    = (state_q == DONE);
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_l2cache_victim_writeback.sv
// Directed bench for the L2 victim writeback block; expected values are hand-derived constants.
module tb_l2cache_victim_writeback;

    logic         clk = 1'b0;
    logic         rst;
    logic         evict_req;
    logic [2:0]   index;
    logic         lru;
    logic         valid_0, valid_1, dirty_0, dirty_1;
    logic [23:0]  tag_0, tag_1;
    logic [255:0] data_0, data_1;
    logic         pmem_resp;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         victim_way;
    logic         clear_dirty_0, clear_dirty_1;
    logic         evict_done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] DEAD_LINE  = {8{32'hDEADBEEF}};
    localparam logic [255:0] CAFE_LINE  = {8{32'hCAFEF00D}};
    localparam logic [255:0] CLEAN_LINE = {8{32'h12345678}};

    always #5 clk = ~clk;

    l2cache_victim_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .evict_req     (evict_req),
        .index         (index),
        .lru           (lru),
        .valid_0       (valid_0),
        .valid_1       (valid_1),
        .dirty_0       (dirty_0),
        .dirty_1       (dirty_1),
        .tag_0         (tag_0),
        .tag_1         (tag_1),
        .data_0        (data_0),
        .data_1        (data_1),
        .pmem_resp     (pmem_resp),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .victim_way    (victim_way),
        .clear_dirty_0 (clear_dirty_0),
        .clear_dirty_1 (clear_dirty_1),
        .evict_done    (evict_done),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_dirty_way1();
        lru     = 1'b1;
        valid_1 = 1'b1;
        dirty_1 = 1'b1;
        tag_1   = 24'hABCDEF;
        index   = 3'd5;
        data_1  = DEAD_LINE;
    endtask

    initial begin
        rst = 1'b1;
        evict_req = 1'b0; index = '0; lru = 1'b0;
        valid_0 = 1'b0; valid_1 = 1'b0; dirty_0 = 1'b0; dirty_1 = 1'b0;
        tag_0 = '0; tag_1 = '0; data_0 = '0; data_1 = '0;
        pmem_resp = 1'b0;

        tick();
        check("rst_pmem_write", pmem_write, 0);
        check("rst_busy", busy, 0);
        check("rst_evict_done", evict_done, 0);
        check("rst_address", pmem_address, 0);
        check("rst_wdata", pmem_wdata, 0);
        check("rst_victim_way", victim_way, 0);
        rst = 1'b0;
        tick();

        // Clean victim in way 0
        lru = 1'b0; valid_0 = 1'b1; dirty_0 = 1'b0; tag_0 = 24'h111111; data_0 = CLEAN_LINE;
        index = 3'd2; evict_req = 1'b1;
        tick();
        check("clean_done", evict_done, 1);
        check("clean_no_write", pmem_write, 0);
        check("clean_victim", victim_way, 0);
        check("clean_busy", busy, 1);
        evict_req = 1'b0;
        tick();
        check("clean_done_drop", evict_done, 0);
        check("clean_idle", busy, 0);

        // Dirty victim in way 1, with array inputs changing during WB
        load_dirty_way1();
        evict_req = 1'b1;
        tick();
        check("dirty_write", pmem_write, 1);
        check("dirty_address", pmem_address, 32'hABCDEFA0);
        check("dirty_wdata", pmem_wdata, DEAD_LINE);
        check("dirty_victim", victim_way, 1);
        check("dirty_no_clear", clear_dirty_1, 0);
        check("dirty_no_done", evict_done, 0);
        tag_1 = 24'h123456; data_1 = CAFE_LINE; lru = 1'b0; index = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wb_hold_write", pmem_write, 1);
            check("wb_hold_address", pmem_address, 32'hABCDEFA0);
            check("wb_hold_wdata", pmem_wdata, DEAD_LINE);
        end
        pmem_resp = 1'b1;
        #1;
        check("resp_clear1", clear_dirty_1, 1);
        check("resp_clear0", clear_dirty_0, 0);
        check("resp_still_write", pmem_write, 1);
        tick();
        pmem_resp = 1'b0;
        evict_req = 1'b0;
        #1;
        check("dirty_done", evict_done, 1);
        check("dirty_write_drop", pmem_write, 0);
        check("dirty_clear_drop", clear_dirty_1, 0);
        check("dirty_done_victim", victim_way, 1);
        tick();
        check("dirty_idle", busy, 0);

        // Stray ack in IDLE
        pmem_resp = 1'b1;
        #1;
        check("stray_idle_clear0", clear_dirty_0, 0);
        check("stray_idle_clear1", clear_dirty_1, 0);
        tick();
        check("stray_idle_busy", busy, 0);
        pmem_resp = 1'b0;

        // Invalid but dirty-marked way 0; evict_req held through DONE
        lru = 1'b0; valid_0 = 1'b0; dirty_0 = 1'b1;
        evict_req = 1'b1;
        tick();
        check("inv_done", evict_done, 1);
        check("inv_no_write", pmem_write, 0);
        pmem_resp = 1'b1;
        #1;
        check("stray_done_clear0", clear_dirty_0, 0);
        tick();
        check("held_req_idle", busy, 0);
        check("held_req_done_drop", evict_done, 0);
        pmem_resp = 1'b0;
        evict_req = 1'b0;
        tick();

        // LRU picks invalid way 1 even though way 0 is a clean valid line
        lru = 1'b1; valid_1 = 1'b0; dirty_1 = 1'b1; valid_0 = 1'b1; dirty_0 = 1'b0;
        evict_req = 1'b1;
        tick();
        check("lru_inv_victim", victim_way, 1);
        check("lru_inv_done", evict_done, 1);
        evict_req = 1'b0;
        tick();

        // Reset two cycles into WB
        load_dirty_way1();
        evict_req = 1'b1;
        tick();
        evict_req = 1'b0;
        tick();
        tick();
        check("prerst_write", pmem_write, 1);
        pmem_resp = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_write", pmem_write, 0);
        check("midrst_clear1", clear_dirty_1, 0);
        check("midrst_busy", busy, 0);
        check("midrst_address", pmem_address, 0);
        pmem_resp = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Normal dirty eviction after reset
        load_dirty_way1();
        tag_1 = 24'h00FF01; index = 3'd7;
        evict_req = 1'b1;
        tick();
        check("post_address", pmem_address, 32'h00FF01E0);
        check("post_write", pmem_write, 1);
        tick();
        pmem_resp = 1'b1;
        #1;
        check("post_clear1", clear_dirty_1, 1);
        tick();
        pmem_resp = 1'b0;
        evict_req = 1'b0;
        #1;
        check("post_done", evict_done, 1);
        tick();
        check("post_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
